// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional build macro: REGFILE_ZERO_REG_EN (index 0 hardwired to zero).
package regfile_mp_pkg;

  localparam int REGFILE_IDX_W_DEF = 3;
  localparam int REGFILE_REG_W_DEF = 32;
  localparam int REGFILE_N_RD_DEF  = 2;
  localparam int REGFILE_ZERO_IDX  = 0;

  // True when a register index may be written or marked pending.
  function automatic logic idx_writable(input int unsigned idx);
`ifdef REGFILE_ZERO_REG_EN
    return (idx != REGFILE_ZERO_IDX);
`else
    return 1'b1;
`endif
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle between issue/writeback (master) and the register file (slave).
// No ready/valid handshake: every field is sampled by the register file on each
// posedge, and rdata/rbusy answer the raddr presented one edge earlier.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int IDX_W = REGFILE_IDX_W_DEF,
  parameter int REG_W = REGFILE_REG_W_DEF,
  parameter int N_RD  = REGFILE_N_RD_DEF
) ();

  logic [N_RD*IDX_W-1:0] raddr;
  logic [N_RD*REG_W-1:0] rdata;
  logic [N_RD-1:0]       rbusy;

  logic                  we0;
  logic [IDX_W-1:0]      waddr0;
  logic [REG_W-1:0]      wdata0;
  logic                  we1;
  logic [IDX_W-1:0]      waddr1;
  logic [REG_W-1:0]      wdata1;

  logic                  mark_en;
  logic [IDX_W-1:0]      mark_idx;
  logic                  any_busy;

  modport master (
    output raddr,
    output we0, waddr0, wdata0,
    output we1, waddr1, wdata1,
    output mark_en, mark_idx,
    input  rdata, rbusy, any_busy
  );

  modport slave (
    input  raddr,
    input  we0, waddr0, wdata0,
    input  we1, waddr1, wdata1,
    input  mark_en, mark_idx,
    output rdata, rbusy, any_busy
  );

endinterface

// File: rtl/regfile_mp_rdport.sv
// One read port: write-first forward mux followed by the rdata/rbusy registers.
// Honours REGFILE_ZERO_REG_EN (index 0 reads as zero, never forwarded).
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int IDX_W = REGFILE_IDX_W_DEF,
  parameter int REG_W = REGFILE_REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] raddr,
  input  logic [REG_W-1:0] arr_data,
  input  logic             busy_nxt,
  input  logic             we0,
  input  logic [IDX_W-1:0] waddr0,
  input  logic [REG_W-1:0] wdata0,
  input  logic             we1,
  input  logic [IDX_W-1:0] waddr1,
  input  logic [REG_W-1:0] wdata1,
  output logic [REG_W-1:0] rdata,
  output logic             rbusy
);

  logic [REG_W-1:0] data_nxt;
  logic             busy_sel;

  // Port 1 is tested last so it overrides a same-index port 0 write.
  always_comb begin
    data_nxt = arr_data;
    busy_sel = busy_nxt;
    if (we0 && (waddr0 == raddr)) data_nxt = wdata0;
    if (we1 && (waddr1 == raddr)) data_nxt = wdata1;
`ifdef REGFILE_ZERO_REG_EN
    if (raddr == IDX_W'(REGFILE_ZERO_IDX)) begin
      data_nxt = '0;
      busy_sel = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      rbusy <= 1'b0;
    end else begin
      rdata <= data_nxt;
      rbusy <= busy_sel;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two prioritised write ports, N_RD forwarded read
// ports and a per-register pending-write scoreboard. Macro: REGFILE_ZERO_REG_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int IDX_W = REGFILE_IDX_W_DEF,
  parameter int REG_W = REGFILE_REG_W_DEF,
  parameter int N_RD  = REGFILE_N_RD_DEF
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  rf
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [REG_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [DEPTH-1:0] wr0_hit;
  logic [DEPTH-1:0] wr1_hit;
  logic [DEPTH-1:0] mark_hit;

  // One-hot decode of both write ports and the mark request.
  always_comb begin
    wr0_hit  = '0;
    wr1_hit  = '0;
    mark_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr0_hit[i]  = rf.we0 && (rf.waddr0 == IDX_W'(i)) && idx_writable(i);
      wr1_hit[i]  = rf.we1 && (rf.waddr1 == IDX_W'(i)) && idx_writable(i);
      mark_hit[i] = rf.mark_en && (rf.mark_idx == IDX_W'(i)) && idx_writable(i);
    end
  end

  // A mark beats a same-cycle write: the newer producer still owns the register.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_nxt[i] = (pending[i] && !(wr0_hit[i] || wr1_hit[i])) || mark_hit[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr1_hit[i]) begin
          regs[i] <= rf.wdata1;
        end else if (wr0_hit[i]) begin
          regs[i] <= rf.wdata0;
        end
      end
      pending <= pending_nxt;
    end
  end

  assign rf.any_busy = |pending;

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [IDX_W-1:0] ra;
    assign ra = rf.raddr[k*IDX_W +: IDX_W];

    regfile_rdport #(
      .IDX_W (IDX_W),
      .REG_W (REG_W)
    ) u_rdport (
      .clk      (clk),
      .rst      (rst),
      .raddr    (ra),
      .arr_data (regs[ra]),
      .busy_nxt (pending_nxt[ra]),
      .we0      (rf.we0),
      .waddr0   (rf.waddr0),
      .wdata0   (rf.wdata0),
      .we1      (rf.we1),
      .waddr1   (rf.waddr1),
      .wdata1   (rf.wdata1),
      .rdata    (rf.rdata[k*REG_W +: REG_W]),
      .rbusy    (rf.rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp with three read ports: directed cases plus random traffic,
// checked against an array/bit-vector reference model through an expected queue.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int IDX_W = 3;
  localparam int REG_W = 32;
  localparam int N_RD  = 3;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int W     = N_RD*REG_W + N_RD + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.IDX_W(IDX_W), .REG_W(REG_W), .N_RD(N_RD)) rf ();

  regfile_mp #(.IDX_W(IDX_W), .REG_W(REG_W), .N_RD(N_RD)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  logic [REG_W-1:0] m_reg  [DEPTH];
  bit               m_pend [DEPTH];
  logic [W-1:0]     exp_q  [$];
  int               n_chk = 0;
  int               n_err = 0;

  function automatic bit writable(input int idx);
`ifdef REGFILE_ZERO_REG_EN
    return idx != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge, then what every read port should show.
  task automatic model_step(input bit we0, input int wa0, input logic [REG_W-1:0] wd0,
                            input bit we1, input int wa1, input logic [REG_W-1:0] wd1,
                            input bit mk, input int mi,
                            input logic [N_RD*IDX_W-1:0] ra, output logic [W-1:0] e);
    logic [N_RD*REG_W-1:0] ed;
    logic [N_RD-1:0]       eb;
    bit                    any;
    if (we0 && writable(wa0)) m_reg[wa0] = wd0;
    if (we1 && writable(wa1)) m_reg[wa1] = wd1;
    if (we0) m_pend[wa0] = 1'b0;
    if (we1) m_pend[wa1] = 1'b0;
    if (mk && writable(mi)) m_pend[mi] = 1'b1;
    for (int k = 0; k < N_RD; k++) begin
      int idx;
      idx = int'(ra[k*IDX_W +: IDX_W]);
      ed[k*REG_W +: REG_W] = m_reg[idx];
      eb[k] = m_pend[idx];
    end
    any = 1'b0;
    for (int i = 0; i < DEPTH; i++) any = any | m_pend[i];
    e = {ed, eb, any};
  endtask

  task automatic chk(input string name, input logic [REG_W-1:0] got, input logic [REG_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle at negedge, queue its expected outputs, return just after the edge.
  task automatic cycle(input bit we0, input int wa0, input logic [REG_W-1:0] wd0,
                       input bit we1, input int wa1, input logic [REG_W-1:0] wd1,
                       input bit mk, input int mi, input logic [N_RD*IDX_W-1:0] ra);
    logic [W-1:0] e;
    @(negedge clk);
    rf.we0 = we0; rf.waddr0 = IDX_W'(wa0); rf.wdata0 = wd0;
    rf.we1 = we1; rf.waddr1 = IDX_W'(wa1); rf.wdata1 = wd1;
    rf.mark_en = mk; rf.mark_idx = IDX_W'(mi);
    rf.raddr = ra;
    model_step(we0, wa0, wd0, we1, wa1, wd1, mk, mi, ra, e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    rf.we0 = 1'b0; rf.waddr0 = '0; rf.wdata0 = '0;
    rf.we1 = 1'b0; rf.waddr1 = '0; rf.wdata1 = '0;
    rf.mark_en = 1'b0; rf.mark_idx = '0; rf.raddr = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, rf.rdata[REG_W-1:0], '0);
    chk({tag, "_rdata2"}, rf.rdata[2*REG_W +: REG_W], '0);
    chk({tag, "_rbusy"}, REG_W'(rf.rbusy), '0);
    chk({tag, "_any_busy"}, REG_W'(rf.any_busy), '0);
  endtask

  // Monitor: outputs are valid every cycle out of reset; compare with the queue head.
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {rf.rdata, rf.rbusy, rf.any_busy};
        n_chk++;
        if (g !== e) begin
          n_err++;
          $display("FAIL scoreboard @%0t: got %h expected %h", $time, g, e);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset_async");
    @(posedge clk); #1;
    chk_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;

    cycle(0, 0, 0, 0, 0, 0, 0, 0, {3'd5, 3'd5, 3'd5});
    chk("read5_after_reset", rf.rdata[REG_W-1:0], 32'h0);

    cycle(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd0, 3'd3});
    chk("write_read3", rf.rdata[REG_W-1:0], 32'hDEADBEEF);

    cycle(1, 4, 32'h11, 1, 4, 32'h22, 0, 0, {3'd0, 3'd4, 3'd0});
    chk("fwd_prio_rd1", rf.rdata[REG_W +: REG_W], 32'h22);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd0, 3'd4});
    chk("plain_read4", rf.rdata[REG_W-1:0], 32'h22);

    cycle(0, 0, 0, 0, 0, 0, 1, 6, {3'd0, 3'd0, 3'd6});
    chk("mark6_rbusy", REG_W'(rf.rbusy[0]), 32'd1);
    chk("mark6_any_busy", REG_W'(rf.any_busy), 32'd1);
    cycle(1, 6, 32'h5, 0, 0, 0, 1, 6, {3'd0, 3'd0, 3'd6});
    chk("write_mark6_busy", REG_W'(rf.rbusy[0]), 32'd1);
    cycle(0, 0, 0, 1, 6, 32'h7, 0, 0, {3'd0, 3'd0, 3'd6});
    chk("write6_rbusy", REG_W'(rf.rbusy[0]), 32'd0);
    chk("write6_any_busy", REG_W'(rf.any_busy), 32'd0);

    cycle(1, 1, 32'hA, 1, 2, 32'hB, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, {3'd1, 3'd2, 3'd1});
    chk("multi_rd0", rf.rdata[0 +: REG_W], 32'hA);
    chk("multi_rd1", rf.rdata[REG_W +: REG_W], 32'hB);
    chk("multi_rd2", rf.rdata[2*REG_W +: REG_W], 32'hA);

    cycle(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, {3'd0, 3'd0, 3'd0});
    cycle(0, 0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd0, 3'd0});
`ifdef REGFILE_ZERO_REG_EN
    chk("zero_reg_rdata", rf.rdata[REG_W-1:0], 32'h0);
    chk("zero_reg_rbusy", REG_W'(rf.rbusy[0]), 32'd0);
    chk("zero_reg_any_busy", REG_W'(rf.any_busy), 32'd0);
`else
    chk("idx0_rdata", rf.rdata[REG_W-1:0], 32'hFFFF);
    chk("idx0_rbusy", REG_W'(rf.rbusy[0]), 32'd1);
    chk("idx0_any_busy", REG_W'(rf.any_busy), 32'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom(),
            $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom(),
            ($urandom_range(0, 2) == 0), $urandom_range(0, DEPTH-1),
            (N_RD*IDX_W)'($urandom()));
    end

    // Reset mid-operation, away from any clock edge.
    cycle(0, 0, 0, 0, 0, 0, 1, 3, {3'd3, 3'd1, 3'd4});
    #1 rst = 1'b1;
    idle_inputs();
    model_reset();
    #1 chk_reset_outputs("reset_midop");
    @(posedge clk); #1;
    chk_reset_outputs("reset_midop_held");
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, {3'd5, 3'd3, 3'd4});
    chk("read5_after_midop", rf.rdata[REG_W-1:0], 32'h0);
    chk("busy_after_midop", REG_W'(rf.rbusy), 32'h0);

    @(negedge clk);
    idle_inputs();
    chk("queue_drained", REG_W'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
